stream_pipe: RTL

Parametrised N-stage register pipeline for valid/ready streams, and the successor to the fixed-latency stream delay line. Every stage honours backpressure: data is held, never overwritten or dropped, while the consumer stalls. Empty stages collapse so the pipe fills fully under a stall. A synchronous flush lets the OoO core discard in-flight beats on redirect or mispredict, and an occupancy count is exported for credit and debug logic.

---
 rtl/stream_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/stream_pipe.sv
// N-stage valid/ready register pipeline with backpressure, bubble collapse,
// synchronous flush and an occupancy count. N=0 degenerates to wires.
module stream_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 1,
  localparam int CW    = (N > 0) ? $clog2(N + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_o,
  output logic [CW-1:0]    count_o
);

  if (N == 0) begin : g_pass
    logic unused_s;
    assign unused_s = ^{clk, reset, flush};
    assign data_o   = data_i;
    assign valid_o  = valid_i;
    assign ready_i  = ready_o;
    assign count_o  = '0;
  end else begin : g_pipe
    logic [N-1:0]     v_q, v_d;
    logic [WIDTH-1:0] d_q [N];
    logic [WIDTH-1:0] d_d [N];
    logic [N-1:0]     en_s;
    logic [N:0]       v_chain_s;
    logic [WIDTH-1:0] d_chain_s [N+1];
    logic [CW-1:0]    cnt_s;

    // Stage k may load when any stage from k to the output is empty or the
    // consumer is ready; accumulated from the output side to avoid a comb loop.
    always_comb begin
      logic acc;
      en_s = '0;
      acc  = ready_o;
      for (int k = N - 1; k >= 0; k--) begin
        acc     = acc | ~v_q[k];
        en_s[k] = acc;
      end
    end

    // Each stage's source: the upstream port for stage 0, else the previous stage.
    always_comb begin
      v_chain_s    = {v_q, valid_i};
      d_chain_s[0] = data_i;
      for (int k = 0; k < N; k++) begin
        d_chain_s[k+1] = d_q[k];
      end
    end

    // Next state per stage: load from the source when enabled, else hold.
    always_comb begin
      v_d = v_q;
      for (int k = 0; k < N; k++) begin
        d_d[k] = d_q[k];
        if (en_s[k]) begin
          v_d[k] = v_chain_s[k];
          d_d[k] = d_chain_s[k];
        end else begin
          v_d[k] = v_q[k];
          d_d[k] = d_q[k];
        end
      end
    end

    // Valid bits: reset and flush both empty the pipe, overriding the enables.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= '0;
      end else if (flush) begin
        v_q <= '0;
      end else begin
        v_q <= v_d;
      end
    end

    // Payload registers carry no reset; invalid stages are don't-care.
    always_ff @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
        d_q[k] <= d_d[k];
      end
    end

    // Occupancy from the registered valid bits only.
    always_comb begin
      cnt_s = '0;
      for (int k = 0; k < N; k++) begin
        cnt_s = cnt_s + CW'(v_q[k]);
      end
    end

    assign ready_i = en_s[0];
    assign valid_o = v_q[N-1];
    assign data_o  = d_q[N-1];
    assign count_o = cnt_s;
  end

endmodule
